dot_product_system: RTL and testbench

- Self-contained dot-product engine for two unsigned vectors of VECTOR_WIDTH elements.
- A write port loads element pairs into two internal vector memories (A and B).
- A compute command sequences reads from both memories through a pipelined multiply-accumulate unit and reports the scalar result.
- A side-band read port lets a host inspect either memory directly.

---
 rtl/dot_product_if.sv | 38 +++
 rtl/dot_product_system.sv | 187 ++++++++++++++++++
 tb/tb_dot_product_system.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_if.sv
// Host-side bus of the dot-product engine: write session, compute command
// and side-band memory reads grouped into one interface.
interface dot_product_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int RESULT_WIDTH = 18
);
    logic                    start;
    logic                    in_valid;
    logic [DATA_WIDTH-1:0]   data_a;
    logic [DATA_WIDTH-1:0]   data_b;
    logic                    busy;
    logic                    done;
    logic                    rd_en_a;
    logic                    rd_en_b;
    logic [ADDR_WIDTH-1:0]   rd_addr_a;
    logic [ADDR_WIDTH-1:0]   rd_addr_b;
    logic [DATA_WIDTH-1:0]   dout_a;
    logic [DATA_WIDTH-1:0]   dout_b;
    logic                    compute_start;
    logic [RESULT_WIDTH-1:0] dot_product_result;
    logic                    result_valid;
    logic                    processing_done;

    modport master (
        output start, in_valid, data_a, data_b,
        output rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, compute_start,
        input  busy, done, dout_a, dout_b,
        input  dot_product_result, result_valid, processing_done
    );

    modport slave (
        input  start, in_valid, data_a, data_b,
        input  rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, compute_start,
        output busy, done, dout_a, dout_b,
        output dot_product_result, result_valid, processing_done
    );
endinterface

// File: rtl/dot_product_system.sv
// Dot-product engine: two vector memories loaded by a write session, read
// back through a 3-stage multiply-accumulate pipeline on a compute command.
module dot_product_system #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int DEPTH        = VECTOR_WIDTH * DATA_WIDTH,
    parameter int ADDR_WIDTH   = 5,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH)
) (
    input logic          clk,
    input logic          rst_n,
    dot_product_if.slave bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_WIDTH - 1);

    typedef enum logic {W_IDLE, W_WRITE} wstate_t;
    typedef enum logic [1:0] {C_IDLE, C_READ, C_DRAIN} cstate_t;

    function automatic logic [PROD_W-1:0] mult_full(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        return {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    endfunction

    function automatic logic [RESULT_WIDTH-1:0] widen(input logic [PROD_W-1:0] p);
        return {{(RESULT_WIDTH - PROD_W){1'b0}}, p};
    endfunction

    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];

    wstate_t               wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  done_q, done_d;
    logic                  wr_en;

    cstate_t               cstate_q, cstate_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  issue, last_issue, clear;

    logic [DATA_WIDTH-1:0]   a_p0_q, b_p0_q, dout_a_q, dout_b_q;
    logic [PROD_W-1:0]       prod_p1_q;
    logic [RESULT_WIDTH-1:0] acc_p2_q, result_q;
    logic vld_p0_q, vld_p1_q, last_p0_q, last_p1_q, last_p2_q;
    logic result_valid_q, pdone_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q <= W_IDLE;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
            cstate_q <= C_IDLE;
            rd_ptr_q <= '0;
        end else begin
            wstate_q <= wstate_d;
            wr_ptr_q <= wr_ptr_d;
            done_q   <= done_d;
            cstate_q <= cstate_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        wr_ptr_d = wr_ptr_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (bus.start && cstate_q == C_IDLE) begin
                    wstate_d = W_WRITE;
                    wr_ptr_d = '0;
                end
            end
            W_WRITE: begin
                if (bus.in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wstate_d = W_IDLE;
                        done_d   = 1'b1;
                    end
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // A simultaneous start takes priority, so compute_start is dropped then.
    always_comb begin
        cstate_d   = cstate_q;
        rd_ptr_d   = rd_ptr_q;
        issue      = 1'b0;
        last_issue = 1'b0;
        clear      = 1'b0;
        case (cstate_q)
            C_IDLE: begin
                if (bus.compute_start && !bus.start && wstate_q == W_IDLE) begin
                    cstate_d = C_READ;
                    rd_ptr_d = '0;
                    clear    = 1'b1;
                end
            end
            C_READ: begin
                issue    = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (rd_ptr_q == LAST_ADDR) begin
                    last_issue = 1'b1;
                    cstate_d   = C_DRAIN;
                end
            end
            C_DRAIN: begin
                if (last_p2_q) cstate_d = C_IDLE;
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[wr_ptr_q] <= bus.data_a;
            mem_b[wr_ptr_q] <= bus.data_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0_q         <= '0;
            b_p0_q         <= '0;
            vld_p0_q       <= 1'b0;
            last_p0_q      <= 1'b0;
            prod_p1_q      <= '0;
            vld_p1_q       <= 1'b0;
            last_p1_q      <= 1'b0;
            acc_p2_q       <= '0;
            last_p2_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            pdone_q        <= 1'b0;
        end else begin
            // stage 1: memory read
            vld_p0_q  <= issue;
            last_p0_q <= last_issue;
            if (issue) begin
                a_p0_q <= mem_a[rd_ptr_q];
                b_p0_q <= mem_b[rd_ptr_q];
            end
            // stage 2: full-width product
            vld_p1_q  <= vld_p0_q;
            last_p1_q <= last_p0_q;
            if (vld_p0_q) prod_p1_q <= mult_full(a_p0_q, b_p0_q);
            // stage 3: accumulate
            last_p2_q <= last_p1_q;
            if (clear)         acc_p2_q <= '0;
            else if (vld_p1_q) acc_p2_q <= acc_p2_q + widen(prod_p1_q);
            // result publish, one cycle after the last accumulation
            result_valid_q <= last_p2_q;
            if (clear) begin
                result_q <= '0;
                pdone_q  <= 1'b0;
            end else if (last_p2_q) begin
                result_q <= acc_p2_q;
                pdone_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            if (bus.rd_en_a)
                dout_a_q <= (int'(bus.rd_addr_a) < DEPTH) ? mem_a[bus.rd_addr_a] : '0;
            if (bus.rd_en_b)
                dout_b_q <= (int'(bus.rd_addr_b) < DEPTH) ? mem_b[bus.rd_addr_b] : '0;
        end
    end

    assign bus.busy               = (wstate_q == W_WRITE);
    assign bus.done               = done_q;
    assign bus.dout_a             = dout_a_q;
    assign bus.dout_b             = dout_b_q;
    assign bus.dot_product_result = result_q;
    assign bus.result_valid       = result_valid_q;
    assign bus.processing_done    = pdone_q;
endmodule

// File: tb/tb_dot_product_system.sv
// Randomized self-checking bench for dot_product_system with a plain-arithmetic
// dot-product reference model.
module tb_dot_product_system;
    localparam int DW = 8;
    localparam int VW = 4;
    localparam int AW = 5;
    localparam int RW = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_product_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) bus ();

    dot_product_system #(
        .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int rv_cnt   = 0;

    logic [DW-1:0] va [VW];
    logic [DW-1:0] vb [VW];

    always @(negedge clk) begin
        if (bus.done)         done_cnt++;
        if (bus.result_valid) rv_cnt++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_dot();
        longint s = 0;
        for (int i = 0; i < VW; i++) s += longint'(va[i]) * longint'(vb[i]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int a0, a1, a2, a3, b0, b1, b2, b3);
        va[0] = DW'(a0); va[1] = DW'(a1); va[2] = DW'(a2); va[3] = DW'(a3);
        vb[0] = DW'(b0); vb[1] = DW'(b1); vb[2] = DW'(b2); vb[3] = DW'(b3);
    endtask

    task automatic do_write(input bit gaps, input bit with_cs);
        int d0 = done_cnt;
        bus.start = 1'b1;
        bus.compute_start = with_cs;
        tick();
        bus.start = 1'b0;
        bus.compute_start = 1'b0;
        chk("busy_on", bus.busy, 1);
        for (int i = 0; i < VW; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.data_a = DW'($urandom);
                bus.data_b = DW'($urandom);
                bus.compute_start = (i == 1);
                tick();
                bus.compute_start = 1'b0;
                chk("busy_gap", bus.busy, 1);
            end
            bus.in_valid = 1'b1;
            bus.data_a = va[i];
            bus.data_b = vb[i];
            tick();
            bus.in_valid = 1'b0;
            if (i < VW - 1) chk("busy_mid", bus.busy, 1);
        end
        chk("busy_off", bus.busy, 0);
        chk("done", bus.done, 1);
        tick();
        chk("done_pulse", bus.done, 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    task automatic do_compute(input longint exp);
        int  cyc = 0;
        bit  seen = 0;
        int  r0 = rv_cnt;
        bus.compute_start = 1'b1;
        tick();
        bus.compute_start = 1'b0;
        chk("res_clear", bus.dot_product_result, 0);
        chk("pdone_clear", bus.processing_done, 0);
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (bus.result_valid) seen = 1;
        end
        chk("rv_latency", cyc, VW + 3);
        chk("result", bus.dot_product_result, exp);
        chk("pdone", bus.processing_done, 1);
        tick();
        chk("rv_pulse", bus.result_valid, 0);
        chk("res_hold", bus.dot_product_result, exp);
        chk("pdone_hold", bus.processing_done, 1);
        chk("rv_count", rv_cnt - r0, 1);
    endtask

    task automatic sb_read(input int ia, input int ib);
        bus.rd_en_a = 1'b1;
        bus.rd_en_b = 1'b1;
        bus.rd_addr_a = AW'(ia);
        bus.rd_addr_b = AW'(ib);
        tick();
        bus.rd_en_a = 1'b0;
        bus.rd_en_b = 1'b0;
        bus.rd_addr_a = AW'((ia + 1) % VW);
        bus.rd_addr_b = AW'((ib + 1) % VW);
        chk("dout_a", bus.dout_a, va[ia]);
        chk("dout_b", bus.dout_b, vb[ib]);
        tick();
        chk("dout_a_hold", bus.dout_a, va[ia]);
        chk("dout_b_hold", bus.dout_b, vb[ib]);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rv"}, bus.result_valid, 0);
        chk({tag, "_pdone"}, bus.processing_done, 0);
        chk({tag, "_result"}, bus.dot_product_result, 0);
        chk({tag, "_dout_a"}, bus.dout_a, 0);
        chk({tag, "_dout_b"}, bus.dout_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bus.start = 0; bus.in_valid = 0; bus.data_a = 0; bus.data_b = 0;
        bus.rd_en_a = 0; bus.rd_en_b = 0; bus.rd_addr_a = 0; bus.rd_addr_b = 0;
        bus.compute_start = 0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        set_vec(1, 2, 3, 4, 1, 1, 1, 1);
        do_write(0, 0);
        do_compute(ref_dot());

        set_vec(2, 4, 6, 8, 1, 2, 3, 4);
        do_write(0, 0);
        do_compute(ref_dot());
        sb_read(2, 3);

        set_vec(0, 5, 0, 3, 2, 0, 4, 1);
        do_write(0, 0);
        do_compute(ref_dot());

        set_vec(255, 255, 255, 255, 1, 1, 1, 1);
        do_write(0, 0);
        do_compute(ref_dot());

        set_vec(255, 255, 255, 255, 255, 255, 255, 255);
        do_write(0, 0);
        do_compute(ref_dot());

        // gapped session with a compute_start while busy
        set_vec(9, 8, 7, 6, 5, 4, 3, 2);
        r0 = rv_cnt;
        do_write(1, 0);
        repeat (10) tick();
        chk("cs_while_busy", rv_cnt - r0, 0);
        do_compute(ref_dot());

        // start and compute_start together: write wins
        set_vec(3, 1, 4, 1, 5, 9, 2, 6);
        r0 = rv_cnt;
        do_write(0, 1);
        repeat (10) tick();
        chk("cs_with_start", rv_cnt - r0, 0);
        do_compute(ref_dot());
        sb_read(0, 1);
        bus.rd_en_a = 1'b1; bus.rd_addr_a = AW'(3);
        tick();
        bus.rd_en_a = 1'b0;

        // reset mid-READ
        r0 = rv_cnt;
        bus.compute_start = 1'b1;
        tick();
        bus.compute_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("no_rv_after_reset", rv_cnt - r0, 0);
        chk("pdone_after_reset", bus.processing_done, 0);
        do_compute(ref_dot());

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < VW; i++) begin
                va[i] = DW'($urandom);
                vb[i] = DW'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < VW; i++) va[i] = 8'hFF;
            end
            do_write(bit'($urandom_range(0, 1)), 1'b0);
            do_compute(ref_dot());
            sb_read(int'($urandom_range(0, VW - 1)), int'($urandom_range(0, VW - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
